// File: rtl/branch_predictor.sv
// Dynamic branch predictor: tagged BTB plus saturating counters, bimodal or gshare indexing.
// Define BP_STATS_EN to build the resolved-branch / mispredict statistics counters.

module bp_entry #(
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                btb_we,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [31:0]         wr_tgt,
  input  logic                ctr_we,
  input  logic                ctr_inc,
  output logic                vld,
  output logic [TAG_BITS-1:0] tag,
  output logic [31:0]         tgt,
  output logic [CTR_BITS-1:0] ctr
);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);

  logic                vld_q, vld_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [31:0]         tgt_q, tgt_d;
  logic [CTR_BITS-1:0] ctr_q, ctr_d;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    if (btb_we) begin
      vld_d = 1'b1;
      tag_d = wr_tag;
      tgt_d = wr_tgt;
    end
    if (ctr_we) begin
      if (ctr_inc && ctr_q != CTR_MAX)  ctr_d = ctr_q + 1'b1;
      else if (!ctr_inc && ctr_q != '0) ctr_d = ctr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      tag_q <= '0;
      tgt_q <= '0;
      ctr_q <= CTR_INIT;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      ctr_q <= ctr_d;
    end
  end

  assign vld = vld_q;
  assign tag = tag_q;
  assign tgt = tgt_q;
  assign ctr = ctr_q;
endmodule

module branch_predictor #(
  parameter logic [31:0] TEXT_START = 32'h0040_0000,
  parameter int ENTRIES   = 64,
  parameter int CTR_BITS  = 2,
  parameter int TAG_BITS  = 8,
  parameter int HIST_BITS = 0,
  localparam int IDX = $clog2(ENTRIES),
  localparam int HW  = (HIST_BITS > 0) ? HIST_BITS : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   lookup_pc,
  output logic          pred_taken,
  output logic [31:0]   pred_next_pc,
  output logic [HW-1:0] pred_hist,
  input  logic          update_valid,
  input  logic [31:0]   update_pc,
  input  logic          update_taken,
  input  logic [31:0]   update_target,
  input  logic [HW-1:0] update_hist,
  input  logic          update_pred_taken,
  input  logic [31:0]   update_pred_target,
  output logic          mispredict,
  output logic [31:0]   stat_branches,
  output logic [31:0]   stat_mispredicts
);
  logic [IDX-1:0]      lk_idx, lk_bidx, up_idx, up_bidx, ghr_ext, uh_ext;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic [HW-1:0]       ghr_q, ghr_d;
  logic                hit;

  logic [ENTRIES-1:0]                vld_a, btb_we, ctr_we;
  logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_a;
  logic [ENTRIES-1:0][31:0]          tgt_a;
  logic [ENTRIES-1:0][CTR_BITS-1:0]  ctr_a;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign up_idx = update_pc[IDX+1:2];
  assign lk_tag = lookup_pc[IDX+2+TAG_BITS-1:IDX+2];
  assign up_tag = update_pc[IDX+2+TAG_BITS-1:IDX+2];

  // Bimodal is simply gshare with the history forced to zero.
  assign ghr_ext = (HIST_BITS == 0) ? '0 : IDX'(ghr_q);
  assign uh_ext  = (HIST_BITS == 0) ? '0 : IDX'(update_hist);
  assign lk_bidx = lk_idx ^ ghr_ext;
  assign up_bidx = up_idx ^ uh_ext;

  always_comb begin
    btb_we = '0;
    ctr_we = '0;
    if (update_valid) begin
      btb_we[up_idx]  = update_taken;
      ctr_we[up_bidx] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ent
    bp_entry #(.TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS)) u_ent (
      .clk     (clk),
      .rstn    (rstn),
      .btb_we  (btb_we[gi]),
      .wr_tag  (up_tag),
      .wr_tgt  (update_target),
      .ctr_we  (ctr_we[gi]),
      .ctr_inc (update_taken),
      .vld     (vld_a[gi]),
      .tag     (tag_a[gi]),
      .tgt     (tgt_a[gi]),
      .ctr     (ctr_a[gi])
    );
  end

  // Lookup sees pre-edge state, so a same-cycle update only shows up next cycle.
  assign hit          = vld_a[lk_idx] && (tag_a[lk_idx] == lk_tag);
  assign pred_taken   = hit && ctr_a[lk_bidx][CTR_BITS-1];
  assign pred_next_pc = pred_taken ? tgt_a[lk_idx] : lookup_pc + 32'd4;
  assign pred_hist    = ghr_q;

  assign mispredict = update_valid &&
                      ((update_taken != update_pred_taken) ||
                       (update_taken && (update_target != update_pred_target)));

  // History is trained from the resolved branch, not speculatively at fetch.
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid)
      ghr_d = (HIST_BITS == 0) ? '0 : HW'({update_hist, update_taken});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

`ifdef BP_STATS_EN
  logic [31:0] st_br_q, st_br_d, st_mp_q, st_mp_d;

  always_comb begin
    st_br_d = st_br_q;
    st_mp_d = st_mp_q;
    if (update_valid && st_br_q != 32'hFFFF_FFFF) st_br_d = st_br_q + 32'd1;
    if (mispredict && st_mp_q != 32'hFFFF_FFFF)   st_mp_d = st_mp_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_br_q <= '0;
      st_mp_q <= '0;
    end else begin
      st_br_q <= st_br_d;
      st_mp_q <= st_mp_d;
    end
  end

  assign stat_branches    = st_br_q;
  assign stat_mispredicts = st_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

  // Bits that only feed a slice (pc alignment, upper PC, counter LSBs) are folded here.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc, update_pc, update_hist, ctr_a, TEXT_START};
endmodule
